// File: rtl/perf_counter_unit.sv
// Pipeline performance counters with saturating event counts, a sticky finish flag and a
// restoring divider that periodically recomputes cycles-per-instruction from a snapshot.
module perf_counter_unit #(
    parameter int unsigned WIDTH        = 19,
    parameter int unsigned FINISH_INSTR = 333
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             stall_evt,
    input  logic             arith_evt,
    input  logic             mem_evt,
    input  logic             retire_evt,
    output logic [WIDTH-1:0] cycle_count,
    output logic [WIDTH-1:0] stall_count,
    output logic [WIDTH-1:0] aritmetric_count,
    output logic [WIDTH-1:0] memory_count,
    output logic [WIDTH-1:0] instruction_count,
    output logic [WIDTH-1:0] cpi,
    output logic             cpi_valid,
    output logic             div_busy,
    output logic             finish
);

    localparam int unsigned    IterW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] CntMax = '1;
    // A target the counter can never represent must not alias onto a truncated value.
    localparam bit FinishReachable =
        (FINISH_INSTR != 0) && (64'(FINISH_INSTR) <= 64'(CntMax));
    localparam logic [WIDTH-1:0] FinishVal = WIDTH'(FINISH_INSTR);

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StDone
    } div_state_e;

    // ------------------------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------------------------
    logic [WIDTH-1:0] cycle_q, cycle_d;
    logic [WIDTH-1:0] stall_q, stall_d;
    logic [WIDTH-1:0] arith_q, arith_d;
    logic [WIDTH-1:0] mem_q, mem_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             finish_q, finish_d;
    logic             count_en;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CntMax) ? v : v + WIDTH'(1);
    endfunction

    assign count_en = enable && !finish_q;

    always_comb begin
        cycle_d  = cycle_q;
        stall_d  = stall_q;
        arith_d  = arith_q;
        mem_d    = mem_q;
        instr_d  = instr_q;
        finish_d = finish_q;
        if (clear) begin
            cycle_d  = '0;
            stall_d  = '0;
            arith_d  = '0;
            mem_d    = '0;
            instr_d  = '0;
            finish_d = 1'b0;
        end else if (count_en) begin
            cycle_d = sat_inc(cycle_q);
            if (stall_evt) stall_d = sat_inc(stall_q);
            if (arith_evt) arith_d = sat_inc(arith_q);
            if (mem_evt)   mem_d   = sat_inc(mem_q);
            // Finish only fires on an actual increment, never on a held saturated value.
            if (retire_evt && (instr_q != CntMax)) begin
                instr_d = instr_q + WIDTH'(1);
                if (FinishReachable && (instr_d == FinishVal)) finish_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q  <= '0;
            stall_q  <= '0;
            arith_q  <= '0;
            mem_q    <= '0;
            instr_q  <= '0;
            finish_q <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            stall_q  <= stall_d;
            arith_q  <= arith_d;
            mem_q    <= mem_d;
            instr_q  <= instr_d;
            finish_q <= finish_d;
        end
    end

    // ------------------------------------------------------------------------------------
    // CPI divider: restoring, one quotient bit per cycle, MSB first
    // ------------------------------------------------------------------------------------
    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [IterW-1:0] iter_q, iter_d;
    logic [WIDTH-1:0] cpi_q, cpi_d;
    logic             cpi_valid_q, cpi_valid_d;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] trial;
    logic             q_bit;

    assign rem_shift = {rem_q, dividend_q[WIDTH-1]};
    assign trial     = rem_shift - {2'b00, divisor_q};
    assign q_bit     = ~trial[WIDTH+1];

    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        iter_d      = iter_q;
        cpi_d       = cpi_q;
        cpi_valid_d = 1'b0;
        if (clear) begin
            state_d    = StIdle;
            dividend_d = '0;
            divisor_d  = '0;
            rem_d      = '0;
            quo_d      = '0;
            iter_d     = '0;
            cpi_d      = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (instr_q != '0) begin
                        dividend_d = cycle_q;
                        divisor_d  = instr_q;
                        rem_d      = '0;
                        quo_d      = '0;
                        iter_d     = '0;
                        state_d    = StDiv;
                    end
                end
                StDiv: begin
                    rem_d      = q_bit ? trial[WIDTH:0] : rem_shift[WIDTH:0];
                    quo_d      = (quo_q << 1) | WIDTH'(q_bit);
                    dividend_d = dividend_q << 1;
                    iter_d     = iter_q + IterW'(1);
                    if (iter_q == IterW'(WIDTH - 1)) begin
                        cpi_d       = quo_d;
                        cpi_valid_d = 1'b1;
                        state_d     = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            iter_q      <= '0;
            cpi_q       <= '0;
            cpi_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            iter_q      <= iter_d;
            cpi_q       <= cpi_d;
            cpi_valid_q <= cpi_valid_d;
        end
    end

    assign cycle_count       = cycle_q;
    assign stall_count       = stall_q;
    assign aritmetric_count  = arith_q;
    assign memory_count      = mem_q;
    assign instruction_count = instr_q;
    assign cpi               = cpi_q;
    assign cpi_valid         = cpi_valid_q;
    assign div_busy          = (state_q != StIdle);
    assign finish            = finish_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: a queue-based scoreboard checks every CPI pulse against a
// behavioural model; directed cases cover reset, saturation, finish and division abort.
module tb_perf_counter_unit;

    localparam int unsigned W    = 19;
    localparam int unsigned FIN  = 333;
    localparam int unsigned MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1, clear = 1'b0;
    logic stall_evt = 1'b1, arith_evt = 1'b1, mem_evt = 1'b1, retire_evt = 1'b1;

    logic [W-1:0] cyc, stl, ari, mem, ins, cpi;
    logic         cpi_valid, div_busy, finish;
    logic [3:0]   s_cyc, s_stl, s_ari, s_mem, s_ins, s_cpi;
    logic         s_cpi_valid, s_div_busy, s_finish;
    logic [W-1:0] f_cyc, f_stl, f_ari, f_mem, f_ins, f_cpi;
    logic         f_cpi_valid, f_div_busy, f_finish;

    perf_counter_unit #(.WIDTH(W), .FINISH_INSTR(FIN)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .stall_evt(stall_evt), .arith_evt(arith_evt), .mem_evt(mem_evt),
        .retire_evt(retire_evt), .cycle_count(cyc), .stall_count(stl),
        .aritmetric_count(ari), .memory_count(mem), .instruction_count(ins),
        .cpi(cpi), .cpi_valid(cpi_valid), .div_busy(div_busy), .finish(finish)
    );

    perf_counter_unit #(.WIDTH(4), .FINISH_INSTR(333)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .stall_evt(stall_evt), .arith_evt(arith_evt), .mem_evt(mem_evt),
        .retire_evt(retire_evt), .cycle_count(s_cyc), .stall_count(s_stl),
        .aritmetric_count(s_ari), .memory_count(s_mem), .instruction_count(s_ins),
        .cpi(s_cpi), .cpi_valid(s_cpi_valid), .div_busy(s_div_busy), .finish(s_finish)
    );

    perf_counter_unit #(.WIDTH(W), .FINISH_INSTR(3)) dut_fin (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .stall_evt(stall_evt), .arith_evt(arith_evt), .mem_evt(mem_evt),
        .retire_evt(retire_evt), .cycle_count(f_cyc), .stall_count(f_stl),
        .aritmetric_count(f_ari), .memory_count(f_mem), .instruction_count(f_ins),
        .cpi(f_cpi), .cpi_valid(f_cpi_valid), .div_busy(f_div_busy), .finish(f_finish)
    );

    always #5 clk = ~clk;

    longint edge_n = 0;
    always @(posedge clk) edge_n++;

    int unsigned total = 0, bad = 0;

    typedef struct {
        longint      due;
        int unsigned cpi;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state, describing the DUT after the most recently modelled edge
    int unsigned m_cyc, m_stall, m_arith, m_mem, m_instr, m_cpi, pend_cpi;
    bit          m_fin, m_busy, pend, mon_on = 1'b0;
    longint      pend_due, last_snap, free_edge, busy_until;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned inc(input int unsigned v);
        return (v == MAXV) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_stall = 0; m_arith = 0; m_mem = 0; m_instr = 0; m_cpi = 0;
        m_fin = 0; m_busy = 0; pend = 0; sb_q.delete();
        free_edge = 0; busy_until = -1; last_snap = -100;
    endtask

    // Drive one cycle of inputs, predict the coming edge, then advance to the next negedge.
    task automatic step(input bit en, input bit clr, input bit st, input bit ar,
                        input bit me, input bit re);
        longint k;
        enable = en; clear = clr;
        stall_evt = st; arith_evt = ar; mem_evt = me; retire_evt = re;
        k = edge_n + 1;
        if (clr) begin
            m_cyc = 0; m_stall = 0; m_arith = 0; m_mem = 0; m_instr = 0;
            m_cpi = 0; m_fin = 0;
            if (pend) begin
                pend = 0;
                void'(sb_q.pop_back());
            end
            busy_until = -1;
            free_edge  = k + 1;
        end else begin
            if (pend && pend_due == k) begin
                m_cpi = pend_cpi;
                pend  = 0;
            end
            if (k >= free_edge && m_instr != 0) begin
                pend       = 1;
                pend_due   = k + W;
                pend_cpi   = m_cyc / m_instr;
                last_snap  = k;
                free_edge  = k + W + 2;
                busy_until = k + W;
                sb_q.push_back('{due: k + W, cpi: m_cyc / m_instr});
            end
            if (en && !m_fin) begin
                m_cyc = inc(m_cyc);
                if (st) m_stall = inc(m_stall);
                if (ar) m_arith = inc(m_arith);
                if (me) m_mem   = inc(m_mem);
                if (re && m_instr < MAXV) begin
                    m_instr++;
                    if (m_instr == FIN) m_fin = 1;
                end
            end
        end
        m_busy = (k <= busy_until);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the main instance against the model and consumes scoreboard entries.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_on) begin
            check("cycle_count", cyc, m_cyc);
            check("stall_count", stl, m_stall);
            check("aritmetric_count", ari, m_arith);
            check("memory_count", mem, m_mem);
            check("instruction_count", ins, m_instr);
            check("finish", finish, m_fin);
            check("div_busy", div_busy, m_busy);
            check("cpi", cpi, m_cpi);
            while (sb_q.size() > 0 && sb_q[0].due < edge_n) begin
                total++; bad++;
                $display("FAIL cpi_valid missing: got none, expected pulse at edge %0d",
                         sb_q[0].due);
                void'(sb_q.pop_front());
            end
            if (cpi_valid) begin
                if (sb_q.size() > 0 && sb_q[0].due == edge_n) begin
                    e = sb_q.pop_front();
                    check("cpi at pulse", cpi, e.cpi);
                end else begin
                    total++; bad++;
                    $display("FAIL cpi_valid unexpected: got pulse at edge %0d, expected none",
                             edge_n);
                end
            end
        end
    end

    initial begin
        int          n_p;
        longint      t_prev, t_last;
        int unsigned c_prev, c_last;
        bit          found;

        // Reset with every strobe high, released on a negedge and sampled before any edge
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst cycle_count", cyc, 0);
        check("rst stall_count", stl, 0);
        check("rst aritmetric_count", ari, 0);
        check("rst memory_count", mem, 0);
        check("rst instruction_count", ins, 0);
        check("rst cpi", cpi, 0);
        check("rst cpi_valid", cpi_valid, 0);
        check("rst div_busy", div_busy, 0);
        check("rst finish", finish, 0);
        model_reset();
        mon_on = 1'b1;
        step(0, 1, 0, 0, 0, 0);

        // Counting and CPI on frozen operands
        for (int i = 1; i <= 12; i++) step(1, 0, 0, 0, 0, (i % 4) == 0);
        check("t1 cycle_count", cyc, 12);
        check("t1 instruction_count", ins, 3);
        n_p = 0; t_prev = 0; t_last = 0; c_prev = 0; c_last = 0;
        for (int i = 0; i < 80; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (cpi_valid) begin
                n_p++;
                t_prev = t_last; c_prev = c_last;
                t_last = edge_n; c_last = cpi;
            end
        end
        check("t1 pulses seen >= 2", n_p >= 2, 1);
        check("t1 last cpi", c_last, 4);
        check("t1 previous cpi", c_prev, 4);
        check("t1 pulse period", t_last - t_prev, 21);

        // All strobes in one cycle
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 1);
        check("sim cycle_count", cyc, 1);
        check("sim stall_count", stl, 1);
        check("sim aritmetric_count", ari, 1);
        check("sim memory_count", mem, 1);
        check("sim instruction_count", ins, 1);

        // Saturation on the 4-bit instance
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 1);
        check("sat cycle_count", s_cyc, 15);
        check("sat instruction_count", s_ins, 15);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (s_cpi_valid) begin
                found = 1;
                check("sat cpi", s_cpi, 1);
            end
        end
        check("sat cpi pulse seen", found, 1);

        // Finish on the FINISH_INSTR=3 instance
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check("fin not yet", f_finish, 0);
        step(1, 0, 0, 0, 0, 1);
        check("fin at third", f_finish, 1);
        check("fin instruction_count", f_ins, 3);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 1, 1);
        check("fin held", f_finish, 1);
        check("fin instruction_count held", f_ins, 3);
        check("fin cycle_count held", f_cyc, 3);
        check("fin stall_count frozen", f_stl, 0);

        // Clear at the fifth DIV cycle
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0, i[0]);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pend && (edge_n + 1 == last_snap + 5)) found = 1;
            else step(0, 0, 0, 0, 0, 0);
        end
        check("abort reached DIV", found, 1);
        check("abort busy before", div_busy, 1);
        check("abort cpi nonzero before", cpi != 0, 1);
        step(0, 1, 0, 0, 0, 0);
        check("abort cpi", cpi, 0);
        check("abort div_busy", div_busy, 0);
        check("abort cpi_valid", cpi_valid, 0);
        idle(25);

        // Asynchronous reset in the middle of a division
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 1, 1);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pend && (edge_n + 1 == last_snap + 3)) found = 1;
            else step(0, 0, 0, 0, 0, 0);
        end
        check("arst reached DIV", found, 1);
        check("arst busy before", div_busy, 1);
        mon_on = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst cycle_count", cyc, 0);
        check("arst stall_count", stl, 0);
        check("arst memory_count", mem, 0);
        check("arst instruction_count", ins, 0);
        check("arst cpi", cpi, 0);
        check("arst div_busy", div_busy, 0);
        repeat (2) @(negedge clk);
        stall_evt = 0; arith_evt = 0; mem_evt = 0; retire_evt = 0; enable = 0;
        rst = 1'b0;
        model_reset();
        mon_on = 1'b1;

        // Random traffic with occasional clears, then a long run that reaches finish
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 1200; i++)
            step($urandom_range(0, 3) != 0, 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        check("random finish reached", finish, 1);

        for (int i = 0; i < 50 && pend; i++) step(0, 0, 0, 0, 0, 0);
        check("scoreboard drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
